axo_mem_uart_tx: RTL

Memory-mapped 8N1 UART transmitter that sits on one downstream port of `axo_mem_demux`, alongside the instruction ROM, and consumes CPU stores to its TX data register. Bytes are buffered in an internal FIFO and serialised on `txd` at a fixed divider. It replaces the simulation-only character sink with synthesizable hardware and exposes a status register and a TX-idle interrupt.

---
 rtl/axo_mem_uart_tx_if.sv | 23 ++
 rtl/axo_mem_uart_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axo_mem_uart_tx_if.sv
// axo_mem register bus: one request per cycle, combinational response.
// The master drives the request; the slave answers with rdata/ready/error
// in the same cycle.
interface axo_mem_bus;
    logic        re;
    logic        we;
    logic [1:0]  asize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    modport master (
        output re, we, asize, addr, wdata,
        input  rdata, ready, error
    );

    modport slave (
        input  re, we, asize, addr, wdata,
        output rdata, ready, error
    );
endinterface

// File: rtl/axo_mem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Offset 0 (TXDATA) pushes a byte into a TX FIFO; offset 4 (STATUS) reports
// FIFO/shifter state. The transmitter drains the FIFO at CLK_DIV cycles per
// bit and chains frames with no idle gap while bytes are queued.
module axo_mem_uart_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    axo_mem_bus.slave  bus,
    output logic       txd,
    output logic       irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    // Bus error codes returned in rdata alongside error=1.
    localparam logic [31:0] AXO_MEM_EALIGN   = 32'h0000_0001;
    localparam logic [31:0] AXO_MEM_EASIZE   = 32'h0000_0002;
    localparam logic [31:0] AXO_MEM_READONLY = 32'h0000_0003;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          txd_q;
    logic          irq_q;

    logic          full, empty, busy, push, pop;
    logic [31:0]   status;
    logic          rsp_err, rsp_ready;
    logic [31:0]   rsp_rdata;

    // Address bits above the register offset and the unused data byte lanes.
    logic unused_ok;
    assign unused_ok = ^{bus.addr[31:3], bus.wdata[31:8]};

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign busy  = (state_q != IDLE);
    // Pop on leaving IDLE or on the last stop-bit cycle, whenever data waits.
    assign pop   = !empty && ((state_q == IDLE) ||
                              (state_q == STOP && cnt_q == '0));

    assign status = (32'(level_q) << 8) | {28'h0, irq_q, busy, empty, full};

    // Register decode with prioritised error checks; writes win over reads.
    always_comb begin
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        rsp_ready = 1'b1;
        push      = 1'b0;
        if (bus.we) begin
            if (bus.addr[2]) begin
                rsp_err   = 1'b1;
                rsp_rdata = AXO_MEM_READONLY;
            end else if (bus.addr[1:0] != 2'b00) begin
                rsp_err   = 1'b1;
                rsp_rdata = AXO_MEM_EALIGN;
            end else if (full) begin
                rsp_ready = 1'b0;
            end else begin
                push = 1'b1;
            end
        end else if (bus.re) begin
            if (bus.addr[1:0] != 2'b00) begin
                rsp_err   = 1'b1;
                rsp_rdata = AXO_MEM_EALIGN;
            end else if (bus.asize != 2'd2) begin
                rsp_err   = 1'b1;
                rsp_rdata = AXO_MEM_EASIZE;
            end else if (bus.addr[2]) begin
                rsp_rdata = status;
            end
        end
    end

    assign bus.rdata = rsp_rdata;
    assign bus.ready = rsp_ready;
    assign bus.error = rsp_err;

    // Occupancy: a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW + 1)'(1);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers and level, wrapping modulo the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Transmit FSM with registered txd and irq; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            irq_q <= empty && (state_q == IDLE);
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        cnt_q   <= CNT_LOAD;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_LOAD;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_LOAD;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            cnt_q   <= CNT_LOAD;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd = txd_q;
    assign irq = irq_q;
endmodule
